// File: rtl/img_gray_decimate.sv
// RGB565 -> 8-bit luma stream with frame position tracking and optional 2x2 decimation.
// Define IMG_GRAY_DECIMATE_EN to forward only even-column/even-row pixels.
module img_gray_decimate #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic        clk,
  input  logic        reset,
  output logic        in_ready,
  input  logic        in_valid,
  input  logic        in_sync,
  input  logic [15:0] in_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic        out_sync,
  output logic [7:0]  out_data,
  output logic        frame_done,
  output logic        sync_err
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

`ifdef IMG_GRAY_DECIMATE_EN
  localparam bit DECIM = 1'b1;
`else
  localparam bit DECIM = 1'b0;
`endif

  typedef enum logic {
    WAIT_SYNC,
    ACTIVE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            frame_done_q, frame_done_d;
  logic            sync_err_q, sync_err_d;

  logic            s1_valid_q;
  logic            s1_sync_q;
  logic [15:0]     s1_sum_q;
  logic            out_valid_q;
  logic            out_sync_q;
  logic [7:0]      out_data_q;

  logic            advance;
  logic            accept;
  logic            in_frame;
  logic            col_even;
  logic            row_even;
  logic            keep;
  logic [7:0]      r8, g8, b8;
  logic [15:0]     sum;

  assign advance  = out_ready || !out_valid_q;
  assign accept   = in_valid && advance;
  assign in_ready = advance;

  // Channel expansion by MSB replication, then fixed-point BT.601-style weights (sum of weights = 256).
  always_comb begin
    r8  = {in_data[15:11], in_data[15:13]};
    g8  = {in_data[10:5],  in_data[10:9]};
    b8  = {in_data[4:0],   in_data[4:2]};
    sum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
  end

  // A sync pixel always counts as (0,0), so its parity comes from the restart, not the counters.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    in_frame     = 1'b0;
    col_even     = !col_q[0];
    row_even     = !row_q[0];

    if (accept) begin
      if (in_sync) begin
        in_frame   = 1'b1;
        col_even   = 1'b1;
        row_even   = 1'b1;
        sync_err_d = (state_q == ACTIVE) && ((col_q != '0) || (row_q != '0));
        col_d      = CW'(1);
        row_d      = '0;
        state_d    = ACTIVE;
      end else if (state_q == ACTIVE) begin
        in_frame = 1'b1;
        if (col_q == CW'(IMG_W - 1)) begin
          col_d = '0;
          if (row_q == RW'(IMG_H - 1)) begin
            row_d        = '0;
            frame_done_d = 1'b1;
            state_d      = WAIT_SYNC;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end

    keep = in_frame && (!DECIM || (col_even && row_even));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= WAIT_SYNC;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_sync_q    <= 1'b0;
      s1_sum_q     <= '0;
      out_valid_q  <= 1'b0;
      out_sync_q   <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      if (advance) begin
        s1_valid_q  <= keep;
        s1_sync_q   <= keep && in_sync;
        s1_sum_q    <= sum;
        out_valid_q <= s1_valid_q;
        out_sync_q  <= s1_valid_q && s1_sync_q;
        if (s1_valid_q) begin
          out_data_q <= 8'(s1_sum_q >> 8);
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sync   = out_sync_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule
